// File: rtl/nipcb_recording_framer.sv
// nipcb_recording_framer: buffers 32-bit recording words and emits checksummed byte frames
//   clk, rst            clock, synchronous active-high reset
//   clear, flush        abort/zero pulse, partial-frame request pulse
//   fifo_empty/full/dout/rd   non-FWFT recording FIFO read side
//   m_tdata/tvalid/tready/tlast   byte stream toward the host link
//   busy, overflow, frame_count   status toward the register block
module nipcb_recording_framer #(
  parameter int FRAME_WORDS = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        flush,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  input  logic [31:0] fifo_dout,
  output logic        fifo_rd,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] frame_count
);
  localparam int AW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [8:0] FW = 9'(FRAME_WORDS);
  typedef enum logic [2:0] {COLLECT, HDR, SEQ, LEN, FLAGS, PAYLOAD, CSUM} state_t;
  state_t state, state_n;
  logic [31:0] mem [FRAME_WORDS];
  logic [7:0] count, seq, len, csum, csum_n, pbyte, dn;
  logic [9:0] bidx, bidx_n;
  logic [31:0] word;
  logic flush_pend, rd_inflight, ovf_frame, fl, hs, ovf_cond, entry, idle_drop;
  assign hs = m_tvalid & m_tready;
  assign fifo_rd = (state == COLLECT) & ~fifo_empty & ~flush_pend &
                   (({1'b0, count} + {8'b0, rd_inflight}) < FW);
  assign ovf_cond = fifo_full & ~fifo_rd;
  assign busy = ~((state == COLLECT) & (count == 8'd0));
  assign entry = (state == COLLECT) & (state_n == HDR);
  // a flush with nothing buffered and nothing in flight is simply dropped
  assign idle_drop = (state == COLLECT) & flush_pend & (count == 8'd0) & ~rd_inflight;
  always_comb begin
    state_n = state;
    bidx_n = bidx;
    case (state)
      COLLECT: state_n = (({1'b0, count} == FW) || (flush_pend && count != 8'd0 && !rd_inflight)) ? HDR : COLLECT;
      HDR:     state_n = hs ? SEQ : HDR;
      SEQ:     state_n = hs ? LEN : SEQ;
      LEN:     state_n = hs ? FLAGS : LEN;
      FLAGS: begin
        state_n = hs ? PAYLOAD : FLAGS;
        bidx_n = hs ? 10'd0 : bidx;
      end
      PAYLOAD: begin
        state_n = (hs && bidx == {len, 2'b00} - 10'd1) ? CSUM : PAYLOAD;
        bidx_n = (hs && state_n == PAYLOAD) ? bidx + 10'd1 : bidx;
      end
      CSUM:    state_n = hs ? COLLECT : CSUM;
      default: state_n = COLLECT;
    endcase
  end
  // output bytes are computed for the next state so they come out of registers
  assign word = mem[bidx_n[AW+1:2]];
  assign pbyte = word[{bidx_n[1:0], 3'b000} +: 8];
  assign csum_n = hs ? csum ^ m_tdata : csum;
  assign dn = (state_n == HDR)     ? SYNC_BYTE :
              (state_n == SEQ)     ? seq :
              (state_n == LEN)     ? len :
              (state_n == FLAGS)   ? {7'b0, fl} :
              (state_n == PAYLOAD) ? pbyte :
              (state_n == CSUM)    ? csum_n : 8'd0;
  always_ff @(posedge clk)
    if (rd_inflight) mem[count[AW-1:0]] <= fifo_dout;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= COLLECT;
      count <= '0;
      seq <= '0;
      len <= '0;
      csum <= '0;
      bidx <= '0;
      fl <= 1'b0;
      flush_pend <= 1'b0;
      rd_inflight <= 1'b0;
      ovf_frame <= 1'b0;
      overflow <= 1'b0;
      frame_count <= '0;
      m_tdata <= '0;
      m_tvalid <= 1'b0;
      m_tlast <= 1'b0;
    end else begin
      state <= state_n;
      bidx <= bidx_n;
      m_tvalid <= state_n != COLLECT;
      m_tdata <= dn;
      m_tlast <= state_n == CSUM;
      rd_inflight <= fifo_rd;
      overflow <= overflow | ovf_cond;
      flush_pend <= flush | (flush_pend & ~entry & ~idle_drop);
      ovf_frame <= entry ? 1'b0 : ovf_frame | ovf_cond;
      fl <= entry ? ovf_frame | ovf_cond : fl;
      len <= entry ? count : len;
      csum <= entry ? 8'd0 : csum_n;
      count <= (state == CSUM && hs) ? 8'd0 : rd_inflight ? count + 8'd1 : count;
      seq <= (state == CSUM && hs) ? seq + 8'd1 : seq;
      frame_count <= (state == CSUM && hs) ? frame_count + 16'd1 : frame_count;
    end
  end
endmodule

// File: tb/tb_nipcb_recording_framer.sv
// tb_nipcb_recording_framer: randomized bench with a frame-level reference model
module tb_nipcb_recording_framer;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, flush = 1'b0;
  logic fifo_empty = 1'b1, fifo_full = 1'b0, fifo_rd;
  logic [31:0] fifo_dout = '0;
  logic [7:0] m_tdata;
  logic m_tvalid, m_tready = 1'b1, m_tlast, busy, overflow;
  logic [15:0] frame_count;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  logic [31:0] mb[$];
  logic [7:0] exp_b[$];
  logic exp_l[$];
  logic [7:0] mseq = '0;
  int mfc = 0;
  logic mflag = 1'b0, rnd = 1'b0, rd_s = 1'b0;

  nipcb_recording_framer dut (
    .clk(clk), .rst(rst), .clear(clear), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .overflow(overflow), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // non-FWFT FIFO: a read seen during a cycle pops the word just after the closing edge
  always @(negedge clk) rd_s = fifo_rd;
  always @(posedge clk) begin
    #1;
    if (rd_s && q.size() > 0) fifo_dout = q.pop_front();
    fifo_empty = (q.size() == 0);
  end

  // reference frame: sync, seq, len, flags, payload LSB-first, xor of all prior bytes
  task automatic emit();
    logic [7:0] b[$];
    logic [7:0] x = 8'd0;
    b.push_back(8'hA5);
    b.push_back(mseq);
    b.push_back(8'(mb.size()));
    b.push_back({7'b0, mflag});
    foreach (mb[i]) for (int j = 0; j < 4; j++) b.push_back(8'(mb[i] >> (8 * j)));
    foreach (b[i]) begin
      x ^= b[i];
      exp_b.push_back(b[i]);
      exp_l.push_back(1'b0);
    end
    exp_b.push_back(x);
    exp_l.push_back(1'b1);
    mflag = 1'b0;
    mseq++;
    mfc++;
    mb.delete();
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    mb.push_back(w);
    if (mb.size() == 16) emit();
  endtask

  task automatic model_clear();
    exp_b.delete();
    exp_l.delete();
    mb.delete();
    mseq = '0;
    mfc = 0;
    mflag = 1'b0;
  endtask

  always @(negedge clk)
    if (!rst && !clear && m_tvalid) begin
      if (exp_b.size() == 0) chk("spurious_valid", m_tvalid, 1'b0);
      else begin
        chk("byte", m_tdata, exp_b[0]);
        chk("tlast", m_tlast, exp_l[0]);
        chk("rd_in_emit", fifo_rd, 1'b0);
        if (m_tready) begin
          void'(exp_b.pop_front());
          void'(exp_l.pop_front());
        end
      end
    end

  task automatic cyc();
    @(posedge clk);
    #2;
    if (rnd) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic settle();
    int n = 0;
    while ((exp_b.size() != 0 || q.size() != 0) && n < 5000) begin
      cyc();
      n++;
    end
    chk("settle_timeout", 32'(n < 5000), 1);
    repeat (3) cyc();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    if (mb.size() > 0) emit();
    cyc();
    flush = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_valid", m_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rd", fifo_rd, 0);
    chk("rst_last", m_tlast, 0);
    // full frame, one byte per cycle
    for (int k = 0; k < 16; k++) push(32'h03020100 + 32'h04040404 * k);
    n = 0;
    while (!m_tvalid && n < 100) begin cyc(); n++; end
    n = 0;
    while (m_tvalid && n < 200) begin cyc(); n++; end
    chk("frame_cycles", n, 69);
    settle();
    chk("fc_full", frame_count, 16'(mfc));
    // partial flush, then an empty flush
    for (int k = 0; k < 3; k++) push(32'hDDCCBBAA);
    settle();
    chk("busy_partial", busy, 1);
    do_flush();
    settle();
    chk("fc_partial", frame_count, 16'(mfc));
    do_flush();
    repeat (10) cyc();
    chk("busy_empty_flush", busy, 0);
    chk("fc_empty_flush", frame_count, 16'(mfc));
    // backpressure
    rnd = 1'b1;
    for (int k = 0; k < 16; k++) push($urandom);
    settle();
    rnd = 1'b0;
    m_tready = 1'b1;
    // overflow flag
    fifo_full = 1'b1;
    mflag = 1'b1;
    cyc();
    fifo_full = 1'b0;
    cyc();
    chk("ovf_set", overflow, 1);
    for (int k = 0; k < 32; k++) push($urandom);
    settle();
    chk("ovf_sticky", overflow, 1);
    clear = 1'b1;
    model_clear();
    cyc();
    clear = 1'b0;
    chk("ovf_clear", overflow, 0);
    chk("fc_clear", frame_count, 0);
    // random traffic: words trickle in while frames drain
    rnd = 1'b1;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) begin
        push($urandom);
        repeat ($urandom_range(0, 3)) cyc();
      end
      settle();
      do_flush();
      settle();
      chk("fc_rand", frame_count, 16'(mfc));
    end
    rnd = 1'b0;
    m_tready = 1'b1;
    // sequence wrap over 256 one-word frames
    clear = 1'b1;
    model_clear();
    cyc();
    clear = 1'b0;
    for (int f = 0; f < 256; f++) begin
      push($urandom);
      settle();
      do_flush();
      settle();
    end
    chk("fc_wrap", frame_count, 16'd256);
    push(32'h11223344);
    settle();
    do_flush();
    settle();
    // clear in the middle of the payload
    for (int k = 0; k < 16; k++) push($urandom);
    n = 0;
    while (exp_b.size() > 60 && n < 200) begin cyc(); n++; end
    chk("mid_timeout", 32'(n < 200), 1);
    m_tready = 1'b0;
    clear = 1'b1;
    model_clear();
    cyc();
    clear = 1'b0;
    m_tready = 1'b1;
    chk("clr_valid", m_tvalid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_fc", frame_count, 0);
    for (int k = 0; k < 3; k++) push($urandom);
    settle();
    do_flush();
    settle();
    chk("fc_after_clr", frame_count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
